// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the buffered UART receiver:
//     - rx_state_t   : deserializer FSM state encoding
//     - UART_DATA_W  : payload width of one UART character
//     - clks_per_bit : system clocks per bit time (integer division)
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    st_idle    = 3'd0,
    st_start   = 3'd1,
    st_data    = 3'd2,
    st_stop    = 3'd3,
    st_recover = 3'd4
  } rx_state_t;

  // Truncating division is intentional: the sampling grid is built on whole
  // clock periods, and the residual error is spread across the frame.
  function automatic int clks_per_bit(input int clk_rate, input int baud_rate);
    return clk_rate / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
//   Synchronous show-ahead FIFO. The head entry is presented combinationally on
//   data_out, so a consumer can use the byte in the same cycle it asserts pop.
//
//   Ports
//     clk      in   1      rising-edge clock
//     rst_n    in   1      asynchronous active-low reset (empties the FIFO)
//     push     in   1      write data_in; accepted when not full, or when full
//                          and a pop happens in the same cycle
//     data_in  in   WIDTH  entry to write
//     pop      in   1      remove head entry; ignored while empty
//     data_out out  WIDTH  head entry, all zeros while empty
//     empty    out  1      no entries stored
//     full     out  1      DEPTH entries stored
// -----------------------------------------------------------------------------
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_next;
  logic [AW:0]   count_reg;
  logic [AW:0]   count_next;

  logic do_pop;
  logic do_push;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == FULL_COUNT);

  // A pop in the same cycle frees the slot, so a push into a full FIFO is
  // still accepted when the head is being consumed.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (do_push) begin
      wr_ptr_next = wr_ptr_reg + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_next = rd_ptr_reg + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  assign data_out = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/uart_rx_buffered.sv
// -----------------------------------------------------------------------------
// uart_rx_buffered
//   UART receive front end: 8N1 deserializer feeding a show-ahead receive FIFO.
//   Framing errors and FIFO overflows are reported as registered one-cycle
//   pulses, each appearing the cycle after its cause.
//
//   Parameters
//     CLK_RATE    system clock frequency in Hz
//     BAUD_RATE   line rate in baud (CLK_RATE/BAUD_RATE must be >= 4)
//     FIFO_DEPTH  receive FIFO entries, power of two, >= 2
//
//   Ports
//     CLK_I        in   1  system clock, rising edge
//     RST_NI       in   1  asynchronous active-low reset
//     RXD_I        in   1  serial line, asynchronous to CLK_I, idle high
//     READ_I       in   1  pop request; ignored while RX_EMPTY_O=1
//     RX_EMPTY_O   out  1  FIFO empty
//     DATA_REC_O   out  8  FIFO head byte, 8'h00 when empty
//     RX_FULL_O    out  1  FIFO holds FIFO_DEPTH bytes
//     FRAME_ERR_O  out  1  one-cycle pulse: stop bit sampled as 0
//     OVERFLOW_O   out  1  one-cycle pulse: byte dropped, FIFO full
// -----------------------------------------------------------------------------
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_RATE   = 100_000_000,
  parameter int BAUD_RATE  = 3_000_000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  input  logic                   RXD_I,
  input  logic                   READ_I,
  output logic                   RX_EMPTY_O,
  output logic [UART_DATA_W-1:0] DATA_REC_O,
  output logic                   RX_FULL_O,
  output logic                   FRAME_ERR_O,
  output logic                   OVERFLOW_O
);

  localparam int CPB   = clks_per_bit(CLK_RATE, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(UART_DATA_W);

  // Start bit is confirmed half a bit time after the falling edge; every
  // later sample is one full bit time after the previous one, which keeps
  // all samples near the middle of their bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(UART_DATA_W - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer and edge history
  // ---------------------------------------------------------------------------
  logic sync1_reg;
  logic sync2_reg;
  logic rxd_prev_reg;
  logic rxd;

  assign rxd = sync2_reg;

  // Both stages reset high so a reset never fabricates a start edge.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      sync1_reg    <= 1'b1;
      sync2_reg    <= 1'b1;
      rxd_prev_reg <= 1'b1;
    end else begin
      sync1_reg    <= RXD_I;
      sync2_reg    <= sync1_reg;
      rxd_prev_reg <= sync2_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserializer FSM
  // ---------------------------------------------------------------------------
  rx_state_t              state_reg;
  rx_state_t              state_next;
  logic [CNT_W-1:0]       cnt_reg;
  logic [CNT_W-1:0]       cnt_next;
  logic [IDX_W-1:0]       bit_idx_reg;
  logic [IDX_W-1:0]       bit_idx_next;
  logic [UART_DATA_W-1:0] shift_reg;
  logic [UART_DATA_W-1:0] shift_next;
  logic                   frame_err_reg;
  logic                   frame_err_next;
  logic                   overflow_reg;
  logic                   overflow_next;
  logic                   push;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic [UART_DATA_W-1:0] fifo_data;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    bit_idx_next   = bit_idx_reg;
    shift_next     = shift_reg;
    push           = 1'b0;
    frame_err_next = 1'b0;

    case (state_reg)
      st_idle: begin
        cnt_next = '0;
        if (rxd_prev_reg && !rxd) begin
          state_next = st_start;
        end
      end

      st_start: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rxd) begin
            state_next   = st_data;
            bit_idx_next = '0;
          end else begin
            // Line back high at mid-start: treat as a glitch.
            state_next = st_idle;
          end
        end
      end

      st_data: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rxd, shift_reg[UART_DATA_W-1:1]};
          if (bit_idx_reg == IDX_LAST) begin
            state_next = st_stop;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
          end
        end
      end

      st_stop: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rxd) begin
            push       = 1'b1;
            state_next = st_idle;
          end else begin
            frame_err_next = 1'b1;
            state_next     = st_recover;
          end
        end
      end

      st_recover: begin
        // Wait out a break so it reports a single framing error and its
        // trailing low level cannot be mistaken for a new start bit.
        cnt_next = '0;
        if (rxd) begin
          state_next = st_idle;
        end
      end

      default: begin
        cnt_next   = '0;
        state_next = st_idle;
      end
    endcase
  end

  // A stop-bit push into a full FIFO is lost unless the consumer pops the
  // head in the same cycle.
  assign overflow_next = push && fifo_full && !READ_I;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_reg     <= st_idle;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      shift_reg     <= shift_next;
      frame_err_reg <= frame_err_next;
      overflow_reg  <= overflow_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------------
  uart_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (CLK_I),
    .rst_n    (RST_NI),
    .push     (push),
    .data_in  (shift_reg),
    .pop      (READ_I),
    .data_out (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign RX_EMPTY_O  = fifo_empty;
  assign DATA_REC_O  = fifo_data;
  assign RX_FULL_O   = fifo_full;
  assign FRAME_ERR_O = frame_err_reg;
  assign OVERFLOW_O  = overflow_reg;

endmodule

// File: tb/tb_uart_rx_buffered.sv
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  // Line falls just after edge k: sync1 at k+1, sync2 at k+2, edge seen at
  // k+3 (enter start, count 0), start confirmed at k+11, eight data samples
  // 16 apart end at k+139, stop sample and push at k+155.
  localparam int STOP_EDGE = 155;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd = 1'b1;
  logic       read = 1'b0;
  logic       empty;
  logic [7:0] rx_data;
  logic       full;
  logic       frame_err;
  logic       overflow;

  uart_rx_buffered #(
    .CLK_RATE   (16_000_000),
    .BAUD_RATE  (1_000_000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK_I       (clk),
    .RST_NI      (rst_n),
    .RXD_I       (rxd),
    .READ_I      (read),
    .RX_EMPTY_O  (empty),
    .DATA_REC_O  (rx_data),
    .RX_FULL_O   (full),
    .FRAME_ERR_O (frame_err),
    .OVERFLOW_O  (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int frame_cnt = 0;
  int ovf_cnt = 0;
  int fall_cyc = -1;
  logic empty_prev = 1'b1;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (frame_err === 1'b1) frame_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
    if (empty_prev === 1'b1 && empty === 1'b0) fall_cyc = cyc;
    empty_prev = empty;
  end

  initial begin
    #600_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame, called just after a rising edge. Leaves the line at the
  // stop level. Optionally pulses READ_I so it lands on the push edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit, input bit read_at_push,
                           output int start_cyc, output logic [7:0] head_at_push);
    start_cyc = cyc;
    head_at_push = 8'h00;
    for (int c = 0; c < 10 * CPB; c++) begin
      int b;
      b = c / CPB;
      if (b == 0) rxd = 1'b0;
      else if (b <= 8) rxd = d[b-1];
      else rxd = stop_bit;
      read = read_at_push && (c == STOP_EDGE - 1);
      if (read) head_at_push = rx_data;
      @(posedge clk);
      #1;
    end
    read = 1'b0;
    if (stop_bit && (exp_q.size() < DEPTH || read_at_push)) exp_q.push_back(d);
  endtask

  task automatic pop_one(output logic [7:0] d, output logic e);
    d = rx_data;
    e = empty;
    read = 1'b1;
    @(posedge clk);
    #1;
    read = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({empty, rx_data, full, frame_err, overflow} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_outputs: got %b expected %b",
               {empty, rx_data, full, frame_err, overflow}, {1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    if ({empty, rx_data, full, frame_err, overflow} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) errors++;
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic drain(input string name);
    logic [7:0] d;
    logic e;
    logic [7:0] exp;
    while (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      pop_one(d, e);
      checks++;
      if (e !== 1'b0 || d !== exp) begin
        errors++;
        $display("FAIL %s_pop: got data %h empty %b expected data %h empty 0", name, d, e, exp);
      end
    end
    checks++;
    if (empty !== 1'b1 || rx_data !== 8'h00) begin
      errors++;
      $display("FAIL %s_empty_after: got empty %b data %h expected empty 1 data 00", name, empty, rx_data);
    end
  endtask

  task automatic test_single;
    int st;
    logic [7:0] h;
    send_byte(8'hB1, 1'b1, 1'b0, st, h);
    checks++;
    if (fall_cyc - st !== STOP_EDGE) begin
      errors++;
      $display("FAIL single_latency: got %0d expected %0d", fall_cyc - st, STOP_EDGE);
    end
    checks++;
    if (empty !== 1'b0 || rx_data !== 8'hB1) begin
      errors++;
      $display("FAIL single_head: got empty %b data %h expected empty 0 data b1", empty, rx_data);
    end
    drain("single");
  endtask

  task automatic test_back_to_back;
    int st;
    logic [7:0] h;
    logic [7:0] bytes [4] = '{8'h00, 8'hFF, 8'hB1, 8'h5A};
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1, 1'b0, st, h);
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full: got %b expected 1", full);
    end
    drain("b2b");
  endtask

  task automatic test_overflow;
    int st;
    int o0;
    logic [7:0] h;
    logic [7:0] exp;
    logic [7:0] bytes [4] = '{8'h11, 8'h22, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1, 1'b0, st, h);
    o0 = ovf_cnt;
    send_byte(8'h33, 1'b1, 1'b0, st, h);
    idle(2);
    checks++;
    if (ovf_cnt - o0 !== 1) begin
      errors++;
      $display("FAIL ovf_pulse: got %0d pulses expected 1", ovf_cnt - o0);
    end
    checks++;
    if (full !== 1'b1 || rx_data !== 8'h11) begin
      errors++;
      $display("FAIL ovf_contents: got full %b head %h expected full 1 head 11", full, rx_data);
    end
    drain("ovf_drop");
    for (int i = 0; i < 4; i++) send_byte(bytes[i], 1'b1, 1'b0, st, h);
    o0 = ovf_cnt;
    send_byte(8'h33, 1'b1, 1'b1, st, h);
    idle(2);
    exp = exp_q.pop_front();
    checks++;
    if (h !== exp) begin
      errors++;
      $display("FAIL ovf_read_head: got %h expected %h", h, exp);
    end
    checks++;
    if (ovf_cnt - o0 !== 0) begin
      errors++;
      $display("FAIL ovf_read_pulse: got %0d pulses expected 0", ovf_cnt - o0);
    end
    checks++;
    if (full !== 1'b1) begin
      errors++;
      $display("FAIL ovf_read_full: got %b expected 1", full);
    end
    drain("ovf_read");
  endtask

  task automatic test_glitch;
    int st;
    int f0;
    logic [7:0] h;
    f0 = frame_cnt;
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(40);
    checks++;
    if (empty !== 1'b1 || frame_cnt !== f0) begin
      errors++;
      $display("FAIL glitch: got empty %b frame_errs %0d expected empty 1 frame_errs 0", empty, frame_cnt - f0);
    end
    send_byte(8'h96, 1'b1, 1'b0, st, h);
    drain("glitch_next");
  endtask

  task automatic test_frame_error;
    int st;
    int f0;
    logic [7:0] h;
    f0 = frame_cnt;
    send_byte(8'hA5, 1'b0, 1'b0, st, h);
    idle(40 * CPB);
    rxd = 1'b1;
    idle(3 * CPB);
    checks++;
    if (frame_cnt - f0 !== 1) begin
      errors++;
      $display("FAIL ferr_count: got %0d expected 1", frame_cnt - f0);
    end
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL ferr_nopush: got empty %b expected 1", empty);
    end
    send_byte(8'h3C, 1'b1, 1'b0, st, h);
    drain("ferr_next");
  endtask

  task automatic test_reset_mid;
    int st;
    int st2;
    logic [7:0] h;
    logic [7:0] h2;
    send_byte(8'hC3, 1'b1, 1'b0, st, h);
    send_byte(8'h18, 1'b1, 1'b0, st, h);
    checks++;
    if (empty !== 1'b0 || rx_data !== 8'hC3) begin
      errors++;
      $display("FAIL rstmid_queued: got empty %b head %h expected empty 0 head c3", empty, rx_data);
    end
    fork
      send_byte(8'h81, 1'b1, 1'b0, st2, h2);
      begin
        idle(40);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({empty, rx_data, full, frame_err, overflow} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL rstmid_outputs: got %b expected %b",
                   {empty, rx_data, full, frame_err, overflow}, {1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
        end
      end
    join
    exp_q.delete();
    idle(2);
    rst_n = 1'b1;
    idle(5);
    send_byte(8'h7E, 1'b1, 1'b0, st, h);
    drain("rstmid_next");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_glitch();
    test_frame_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
